csa_final_adder_pipe: RTL

- Consumer end of the 16-to-2 partial-product reduction tree: takes the final SUM row and CARRY row (CARRY weighted <<1) and resolves them into one binary result.
- Pipelined, segmented carry-propagate adder (CPA) with valid/ready handshakes on both sides.
- Sits between the reduction tree and the multiplier result register.
- Accepts one operand pair per cycle; the carry ripples one segment per pipeline stage.

---
 rtl/csa_pkg.sv | 30 +++
 rtl/csa_seg_stage.sv | 91 +++++++++
 rtl/csa_final_adder_pipe.sv | 91 +++++++++
 3 files changed

// File: rtl/csa_pkg.sv
// Shared defaults and arithmetic helpers for the segmented final CPA
// that resolves the reduction tree's SUM/CARRY rows.
package csa_pkg;

  localparam int CSA_WIDTH = 64;
  localparam int CSA_SEG   = 16;
  localparam int CSA_TAG_W = 4;

  // Widest segment the shared adder helper handles; callers zero-extend
  // their segment operands into this width and slice {cout, sum} back out.
  localparam int CSA_ADD_W = 256;

  // Number of pipeline stages: one segment resolved per stage.
  function automatic int csa_stages(input int width, input int seg);
    return width / seg;
  endfunction

  // Segment add: a + b + cin. For a SEG-bit segment held in the low bits,
  // bit SEG of the result is the carry-out and bits [SEG-1:0] the sum.
  function automatic logic [CSA_ADD_W:0] csa_seg_add(
    input logic [CSA_ADD_W-1:0] a,
    input logic [CSA_ADD_W-1:0] b,
    input logic                 cin
  );
    logic [CSA_ADD_W:0] w_total;
    w_total = {1'b0, a} + {1'b0, b} + {{CSA_ADD_W{1'b0}}, cin};
    return w_total;
  endfunction

endpackage

// File: rtl/csa_seg_stage.sv
// One stage of the segmented carry-propagate adder: adds segment IDX of the
// operand rows plus the incoming carry, and registers the partial result,
// the segment carry, the remaining operands, the tag and a valid bit.
module csa_seg_stage
  import csa_pkg::*;
#(
  parameter int WIDTH  = CSA_WIDTH,
  parameter int SEG    = CSA_SEG,
  parameter int TAG_W  = CSA_TAG_W,
  parameter int IDX    = 0,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic             i_adv,
  input  logic [WIDTH-1:0] i_sum,
  input  logic [WIDTH:0]   i_car,
  input  logic [WIDTH-1:0] i_res,
  input  logic             i_cy,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_sum,
  output logic [WIDTH:0]   o_car,
  output logic [WIDTH-1:0] o_res,
  output logic             o_cy,
  output logic [TAG_W-1:0] o_tag
);

  localparam int LSB     = IDX * SEG;
  // The last stage folds the shifted-out carry-row MSB into its carry flag,
  // so that register directly becomes the overflow output.
  localparam bit IS_LAST = (IDX == STAGES - 1);

  logic             r_v;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH:0]   r_car;
  logic [WIDTH-1:0] r_res;
  logic             r_cy;
  logic [TAG_W-1:0] r_tag;

  logic [CSA_ADD_W-1:0] w_a;
  logic [CSA_ADD_W-1:0] w_b;
  logic [CSA_ADD_W:0]   w_add;
  logic [WIDTH-1:0]     w_res_nxt;
  logic                 w_cy_nxt;
  logic                 w_add_unused;

  // Segment adder: resolve this stage's segment and splice it into the result.
  always_comb begin
    w_a                   = '0;
    w_b                   = '0;
    w_a[SEG-1:0]          = i_sum[LSB +: SEG];
    w_b[SEG-1:0]          = i_car[LSB +: SEG];
    w_add                 = csa_seg_add(w_a, w_b, i_cy);
    w_res_nxt             = i_res;
    w_res_nxt[LSB +: SEG] = w_add[SEG-1:0];
    w_cy_nxt              = w_add[SEG] | (IS_LAST && i_car[WIDTH]);
  end

  assign w_add_unused = ^w_add;

  // Stage register: refills whenever the stage advances; payload only on a real entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v   <= 1'b0;
      r_sum <= '0;
      r_car <= '0;
      r_res <= '0;
      r_cy  <= 1'b0;
      r_tag <= '0;
    end else if (i_adv) begin
      r_v <= i_valid;
      if (i_valid) begin
        r_sum <= i_sum;
        r_car <= i_car;
        r_res <= w_res_nxt;
        r_cy  <= w_cy_nxt;
        r_tag <= i_tag;
      end
    end
  end

  assign o_valid = r_v;
  assign o_sum   = r_sum;
  assign o_car   = r_car;
  assign o_res   = r_res;
  assign o_cy    = r_cy;
  assign o_tag   = r_tag;

endmodule

// File: rtl/csa_final_adder_pipe.sv
// Pipelined segmented final adder: turns the reduction tree's SUM row and
// CARRY row (weighted <<1) into one binary result, one segment per stage,
// with valid/ready handshakes on both sides and collapsing bubbles.
module csa_final_adder_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int SEG   = CSA_SEG,
  parameter int TAG_W = CSA_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int STAGES = csa_stages(WIDTH, SEG);

  // Index k is the input of stage k; index STAGES is the last stage's output.
  logic [STAGES:0]  w_vc;
  logic [STAGES:0]  w_cy;
  logic [STAGES:0]  w_adv;
  logic [WIDTH-1:0] w_sum [STAGES+1];
  logic [WIDTH:0]   w_car [STAGES+1];
  logic [WIDTH-1:0] w_res [STAGES+1];
  logic [TAG_W-1:0] w_tag [STAGES+1];
  logic             w_ops_unused;

  assign w_vc[0]  = in_valid;
  assign w_sum[0] = in_sum;
  assign w_car[0] = {in_carry, 1'b0};
  assign w_res[0] = '0;
  assign w_cy[0]  = in_cin;
  assign w_tag[0] = in_tag;

  // Advance chain: a stage moves when it is empty or the stage after it moves.
  always_comb begin
    w_adv         = '0;
    w_adv[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_adv[k] = !w_vc[k+1] || w_adv[k+1];
    end
  end

  generate
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
      csa_seg_stage #(
        .WIDTH  (WIDTH),
        .SEG    (SEG),
        .TAG_W  (TAG_W),
        .IDX    (g),
        .STAGES (STAGES)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_vc[g]),
        .i_adv   (w_adv[g]),
        .i_sum   (w_sum[g]),
        .i_car   (w_car[g]),
        .i_res   (w_res[g]),
        .i_cy    (w_cy[g]),
        .i_tag   (w_tag[g]),
        .o_valid (w_vc[g+1]),
        .o_sum   (w_sum[g+1]),
        .o_car   (w_car[g+1]),
        .o_res   (w_res[g+1]),
        .o_cy    (w_cy[g+1]),
        .o_tag   (w_tag[g+1])
      );
    end
  endgenerate

  // Operands are fully consumed by the last stage.
  assign w_ops_unused = ^{w_sum[STAGES], w_car[STAGES]};

  assign in_ready   = w_adv[0];
  assign out_valid  = w_vc[STAGES];
  assign out_result = w_res[STAGES];
  assign out_ovf    = w_cy[STAGES];
  assign out_tag    = w_tag[STAGES];

endmodule
